// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/gnt/rvalid, feeds decode,
// applies redirects and drains outstanding data-memory ops on FENCE.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          CNT_W           = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fence,
    input  logic [31:0] fence_pc,
    input  logic        mem_issue,
    input  logic        mem_done,
    output logic        mem_stall,
    output logic        fence_busy,
    output logic [31:0] predecessor,
    output logic [31:0] successor
);
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD, S_FENCE} state_t;

    state_t             r_state, w_state_n;
    logic [31:0]        r_pc, w_pc_n, w_target;
    logic               r_squash, w_squash_n;
    logic               r_fence_pend, w_pend_n, w_pend;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               w_gnt, w_hs, w_accept, w_inc, w_dec;

    assign mem_stall = r_cnt == CNT_W'(MAX_OUTSTANDING);

    always_comb begin
        w_target = redirect_pc & ~32'h3;
        w_gnt    = imem_req & imem_gnt;
        w_hs     = instr_valid & instr_ready;
        w_pend   = r_fence_pend | fence;
        // a response is only kept if nothing this cycle invalidates it
        w_accept = (r_state == S_WAIT) & imem_rvalid & ~r_squash & ~redirect_valid & ~fence;
        w_inc    = mem_issue & ~mem_stall;
        w_dec    = mem_done & (r_cnt != '0);
        w_cnt_n  = r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
        case (r_state)
            S_BOOT:  w_state_n = w_pend ? S_FENCE : S_FETCH;
            S_FETCH: w_state_n = w_gnt ? S_WAIT : (w_pend ? S_FENCE : S_FETCH);
            S_WAIT:  w_state_n = !imem_rvalid ? S_WAIT : w_accept ? S_HOLD : (w_pend ? S_FENCE : S_FETCH);
            S_HOLD:  w_state_n = (w_hs | redirect_valid) ? (w_pend ? S_FENCE : S_FETCH) : S_HOLD;
            S_FENCE: w_state_n = (w_cnt_n == '0 && !fence) ? S_FETCH : S_FENCE;
            default: w_state_n = S_BOOT;
        endcase
        w_squash_n = (((r_state == S_FETCH) & w_gnt) | ((r_state == S_WAIT) & ~imem_rvalid)) & (redirect_valid | fence) ? 1'b1 :
                     ((r_state == S_WAIT) & imem_rvalid) ? 1'b0 : r_squash;
        w_pend_n   = fence ? 1'b1 : (r_state == S_FENCE && w_state_n == S_FETCH) ? 1'b0 : r_fence_pend;
        // redirect wins over the fence successor written in the same cycle
        w_pc_n     = redirect_valid ? w_target : fence ? fence_pc + 32'd4 : w_accept ? r_pc + 32'd4 : r_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            r_fence_pend <= 1'b0;
            r_cnt        <= '0;
            imem_req     <= 1'b0;
            imem_addr    <= '0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            fence_busy   <= 1'b0;
            predecessor  <= '0;
            successor    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_squash     <= w_squash_n;
            r_fence_pend <= w_pend_n;
            r_cnt        <= w_cnt_n;
            imem_req     <= (w_state_n == S_FETCH) & ~w_pend_n;
            imem_addr    <= w_pc_n;
            instr_valid  <= w_state_n == S_HOLD;
            fence_busy   <= w_state_n == S_FENCE;
            if (w_accept) begin
                instr    <= imem_rdata;
                instr_pc <= r_pc;
            end
            if (fence) begin
                predecessor <= fence_pc;
                successor   <= fence_pc + 32'd4;
            end
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the soft core. It owns the architectural PC register and sequences fetches to instruction memory over a req/gnt/rvalid handshake. It hands fetched words to decode over a valid/ready handshake, applies redirects from the branch/jump resolution logic, and enforces FENCE ordering. On FENCE it halts fetch, drains outstanding data-memory operations, records the predecessor/successor PCs, and refetches from the successor.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
MAX_OUTSTANDING, 4, maximum in-flight data-memory operations tracked; ≥1.
CNT_W, 3, outstanding-counter width; must hold MAX_OUTSTANDING.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address.
imem_gnt  input  1  request accepted this cycle.
imem_rvalid  input  1  fetch response valid.
imem_rdata  input  32  fetched instruction.
instr_valid  output  1  instruction offered to decode.
instr  output  32  instruction word.
instr_pc  output  32  PC of instr.
instr_ready  input  1  decode accepts.
redirect_valid  input  1  taken branch/jump, one-cycle pulse.
redirect_pc  input  32  redirect target.
fence  input  1  decode issued a FENCE, one-cycle pulse.
fence_pc  input  32  PC of that FENCE.
mem_issue  input  1  data-memory request accepted.
mem_done  input  1  data-memory response returned.
mem_stall  output  1  outstanding count at MAX_OUTSTANDING.
fence_busy  output  1  fence drain in progress.
predecessor  output  32  fence_pc of the last FENCE.
successor  output  32  fence_pc+4 of the last FENCE.

Behaviour:
- Reset (async): pc=RESET_PC, state=BOOT, all outputs 0, outstanding=0, squash=0, fence_pend=0.
- FSM states: BOOT, FETCH, WAIT, HOLD, FENCE.
- BOOT: one idle cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc; both are held stable until imem_gnt.
  - On gnt: go to WAIT.
  - If fence_pend is set, do not request; go to FENCE.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with squash=0: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to HOLD (instr_valid=1 next cycle).
  - On imem_rvalid with squash=1: drop the data, clear squash, go to FETCH (or FENCE if fence_pend).
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until instr_ready.
  - On handshake: go to FETCH (or FENCE if fence_pend or fence this cycle).
- Redirect (highest priority; effective target is redirect_pc with bits[1:0] forced to 0):
  - FETCH, no gnt this cycle: pc<=target, request restarts next cycle.
  - FETCH with gnt, or WAIT without rvalid: pc<=target, squash<=1, go to or stay in WAIT.
  - WAIT with rvalid: drop the response, pc<=target, go to FETCH.
  - HOLD: instr_valid drops next cycle (same-cycle handshake still counts), pc<=target, go to FETCH.
  - FENCE: pc<=target; the drain continues.
- Fence:
  - On a fence pulse: predecessor<=fence_pc, successor<=fence_pc+4, fence_pend<=1, pc<=fence_pc+4.
  - Any in-flight fetch completes first and its response is squashed.
  - FENCE state: fence_busy=1, no imem_req.
  - Exit to FETCH when outstanding==0, evaluated after this cycle's mem_issue/mem_done; clear fence_pend and fence_busy.
  - A redirect arriving in the same cycle as fence takes effect on pc after the fence assignment.
- Outstanding counter:
  - +1 on mem_issue, -1 on mem_done; both in one cycle means no change.
  - Saturates at MAX_OUTSTANDING; mem_issue while mem_stall=1 is ignored.
  - mem_done at 0 is ignored.
  - mem_stall = (count==MAX_OUTSTANDING), combinational.
- Arithmetic: all PC +4 operations are modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
- Reset mid-transaction: state returns immediately to BOOT; late imem_rvalid after reset while in BOOT is ignored.

Test Plan:
- Reset, gnt same cycle as req, rvalid one cycle later with 0x00000013, ready=1 → addresses 0x0, 0x4, 0x8 issued; instr_pc 0x0, 0x4 with instr 0x13.
- Redirect to 0x0000_0102 while in WAIT → response for the old PC dropped (instr_valid stays 0); next imem_addr=0x0000_0100.
- HOLD with instr_ready=0 for 5 cycles → instr/instr_pc unchanged, no new imem_req; ready=1 → fetch of pc+4.
- Three mem_issue, then fence with fence_pc=0x40 → fence_busy=1, predecessor=0x40, successor=0x44, no imem_req; three mem_done (last one same cycle as one issue, then one more done) → exit only when count=0, next imem_addr=0x44.
- Four mem_issue with MAX_OUTSTANDING=4 → mem_stall=1; fifth issue ignored; one done → count=3, mem_stall=0.
- pc=0xFFFF_FFFC fetched → next imem_addr=0x0; reset asserted in WAIT → all outputs 0 immediately; after release, first imem_addr=RESET_PC.
